// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   shift_mode_e  - operation encoding carried down the pipe with each op
//   stage_lo_bit  - first shift-amount bit owned by a given stage
//   stage_nbits   - number of shift-amount bits owned by a given stage
// The amount bits are dealt out LSB-first; the first (L mod STAGES) stages
// get one extra bit so the split stays as even as possible.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    function automatic int stage_nbits(input int s, input int l, input int stages);
        return (l / stages) + ((s < (l % stages)) ? 1 : 0);
    endfunction

    function automatic int stage_lo_bit(input int s, input int l, input int stages);
        int extra;
        extra = (s < (l % stages)) ? s : (l % stages);
        return (s * (l / stages)) + extra;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One stage of the pipelined barrel shifter.
// Applies a conditional shift by 2^k for every amount bit k in [LO, LO+NBITS)
// and registers the result together with mode, full amount, tag and valid.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   flush        - kills the valid bit of this stage
//   adv          - pipeline advance enable (register holds when low)
//   in_*         - operation entering this stage
//   out_*        - registered operation leaving this stage
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int LO    = 0,
    parameter int NBITS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       adv,
    input  logic                       in_valid,
    input  shift_mode_e                in_mode,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output shift_mode_e                out_mode,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH)-1:0]   out_amt,
    output logic [TAG_W-1:0]           out_tag
);

    logic [WIDTH-1:0]         shifted_s;
    logic                     valid_r;
    shift_mode_e              mode_r;
    logic [WIDTH-1:0]         data_r;
    logic [$clog2(WIDTH)-1:0] amt_r;
    logic [TAG_W-1:0]         tag_r;

    // Shift d by 2^k in the given mode. 2^k is always below WIDTH, so the
    // rotate's complementary left shift never reaches a zero amount.
    function automatic logic [WIDTH-1:0] apply_shift(input logic [WIDTH-1:0] d,
                                                     input shift_mode_e      m,
                                                     input int               k);
        logic [WIDTH-1:0] r;
        int               n;
        n = 1 << k;
        case (m)
            SH_SLL:  r = d << n;
            SH_SRL:  r = d >> n;
            SH_SRA:  r = $signed(d) >>> n;
            SH_ROR:  r = (d >> n) | (d << (WIDTH - n));
            default: r = d;
        endcase
        return r;
    endfunction

    // Conditional power-of-two shifts for the amount bits owned by this stage.
    always_comb begin
        shifted_s = in_data;
        for (int k = 0; k < NBITS; k++) begin
            shifted_s = in_amt[LO + k] ? apply_shift(shifted_s, in_mode, LO + k) : shifted_s;
        end
    end

    // Stage register: reset clears all, flush kills the op, otherwise load on advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            mode_r  <= SH_SLL;
            data_r  <= '0;
            amt_r   <= '0;
            tag_r   <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (adv) begin
            valid_r <= in_valid;
            mode_r  <= in_mode;
            data_r  <= shifted_s;
            amt_r   <= in_amt;
            tag_r   <= in_tag;
        end
    end

    assign out_valid = valid_r;
    assign out_mode  = mode_r;
    assign out_data  = data_r;
    assign out_amt   = amt_r;
    assign out_tag   = tag_r;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL / SRL / SRA / ROR) for the execute stage.
// Latency is STAGES cycles, throughput one op per cycle, with a valid/ready
// handshake on both sides. All stages advance together or hold together;
// there is no bubble collapsing, so o_ready simply mirrors the advance enable.
// Ports:
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_flush              - drops every in-flight op and any op offered this cycle
//   i_valid / o_ready    - input handshake
//   i_mode               - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   i_operand_a          - data to shift
//   i_operand_b          - shift amount, only the low $clog2(WIDTH) bits are used
//   i_tag                - tag returned alongside the result
//   o_valid / i_ready    - output handshake
//   o_shift_data, o_tag  - result and its tag, straight from the last stage
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_shift_data,
    output logic [TAG_W-1:0] o_tag
);

    localparam int L = $clog2(WIDTH);

    // Element s is the input of stage s; element STAGES is the pipe output.
    logic             valid_s [STAGES+1];
    shift_mode_e      mode_s  [STAGES+1];
    logic [WIDTH-1:0] data_s  [STAGES+1];
    logic [L-1:0]     amt_s   [STAGES+1];
    logic [TAG_W-1:0] tag_s   [STAGES+1];
    logic             adv_s;
    logic             unused_s;

    assign adv_s   = ~valid_s[STAGES] | i_ready;
    assign o_ready = adv_s;

    // Stage 0 sees a bubble whenever the offered op is not accepted.
    assign valid_s[0] = i_valid & adv_s;
    assign mode_s[0]  = shift_mode_e'(i_mode);
    assign data_s[0]  = i_operand_a;
    assign amt_s[0]   = i_operand_b[L-1:0];
    assign tag_s[0]   = i_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .LO    (stage_lo_bit(s, L, STAGES)),
            .NBITS (stage_nbits(s, L, STAGES))
        ) u_stage (
            .clk       (i_clk),
            .reset     (i_reset),
            .flush     (i_flush),
            .adv       (adv_s),
            .in_valid  (valid_s[s]),
            .in_mode   (mode_s[s]),
            .in_data   (data_s[s]),
            .in_amt    (amt_s[s]),
            .in_tag    (tag_s[s]),
            .out_valid (valid_s[s+1]),
            .out_mode  (mode_s[s+1]),
            .out_data  (data_s[s+1]),
            .out_amt   (amt_s[s+1]),
            .out_tag   (tag_s[s+1])
        );
    end

    assign o_valid      = valid_s[STAGES];
    assign o_shift_data = data_s[STAGES];
    assign o_tag        = tag_s[STAGES];

    // Ignored upper amount bits and the last stage's bookkeeping fields.
    assign unused_s = ^{i_operand_b[WIDTH-1:L], amt_s[STAGES], mode_s[STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed table, backpressure and flush
// sequences on a 32/2 instance, then randomized traffic on 32/2, 8/3 and 64/1
// instances checked against a queue-based reference model.
module tb_shift_pipe;

    localparam int NDUT = 3;
    localparam int W   [NDUT] = '{32, 8, 64};
    localparam int STG [NDUT] = '{2, 3, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            i_reset, i_flush, i_ready;
    logic [NDUT-1:0] valid_v;
    logic [1:0]      mode_bus [NDUT];
    logic [63:0]     a_bus    [NDUT];
    logic [63:0]     b_bus    [NDUT];
    logic [4:0]      tag_bus  [NDUT];

    logic        ov0, ov1, ov2, ordy0, ordy1, ordy2;
    logic [31:0] d0;
    logic [7:0]  d1;
    logic [63:0] d2;
    logic [4:0]  t0, t1, t2;

    shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut0 (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(valid_v[0]),
        .o_ready(ordy0), .i_mode(mode_bus[0]), .i_operand_a(a_bus[0][31:0]),
        .i_operand_b(b_bus[0][31:0]), .i_tag(tag_bus[0]), .o_valid(ov0),
        .i_ready(i_ready), .o_shift_data(d0), .o_tag(t0));

    shift_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(5)) dut1 (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(valid_v[1]),
        .o_ready(ordy1), .i_mode(mode_bus[1]), .i_operand_a(a_bus[1][7:0]),
        .i_operand_b(b_bus[1][7:0]), .i_tag(tag_bus[1]), .o_valid(ov1),
        .i_ready(i_ready), .o_shift_data(d1), .o_tag(t1));

    shift_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5)) dut2 (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(valid_v[2]),
        .o_ready(ordy2), .i_mode(mode_bus[2]), .i_operand_a(a_bus[2]),
        .i_operand_b(b_bus[2]), .i_tag(tag_bus[2]), .o_valid(ov2),
        .i_ready(i_ready), .o_shift_data(d2), .o_tag(t2));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic get_valid(input int d);
        case (d)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_ready(input int d);
        case (d)
            0:       return ordy0;
            1:       return ordy1;
            default: return ordy2;
        endcase
    endfunction

    function automatic logic [63:0] get_data(input int d);
        case (d)
            0:       return {32'd0, d0};
            1:       return {56'd0, d1};
            default: return d2;
        endcase
    endfunction

    function automatic logic [4:0] get_tag(input int d);
        case (d)
            0:       return t0;
            1:       return t1;
            default: return t2;
        endcase
    endfunction

    function automatic logic [63:0] width_mask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Golden model: plain arithmetic from the mode definitions.
    function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input logic [63:0] b,
                                              input logic [1:0] mode, input int w);
        logic [63:0] mask, a, r;
        int sh;
        mask = width_mask(w);
        a    = a_in & mask;
        sh   = int'(b & (w - 1));
        case (mode)
            2'd0: r = (a << sh) & mask;
            2'd1: r = a >> sh;
            2'd2: begin
                r = a >> sh;
                if (a[w-1]) r = r | (~(mask >> sh) & mask);
            end
            default: r = ((a >> sh) | (a << (w - sh))) & mask;
        endcase
        return r;
    endfunction

    task automatic drive0(input logic v, input logic [1:0] m, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] t);
        valid_v[0]  = v;
        mode_bus[0] = m;
        a_bus[0]    = a;
        b_bus[0]    = b;
        tag_bus[0]  = t;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        int          due;
    } op_t;

    vec_t tbl [11];

    op_t  fifo [NDUT][8];
    int   head [NDUT];
    int   cnt  [NDUT];
    int   advs [NDUT];
    logic exp_v [NDUT];

    logic [4:0]  rx_tag  [8];
    logic [31:0] rx_data [8];

    initial begin
        int   rx_cnt, next_tag, stall_left;
        logic prev_stall, rdy, exp_rdy;
        logic [31:0] prev_data;
        logic [4:0]  prev_tag;

        tbl[0]  = '{2'd0, 32'h8000_00F0, 32'd4,          5'd1,  32'h0000_0F00};
        tbl[1]  = '{2'd1, 32'h8000_00F0, 32'd4,          5'd2,  32'h0800_000F};
        tbl[2]  = '{2'd2, 32'h8000_00F0, 32'd4,          5'd3,  32'hF800_000F};
        tbl[3]  = '{2'd3, 32'h8000_00F0, 32'd4,          5'd4,  32'h0800_000F};
        tbl[4]  = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0023,  5'd5,  32'h1FFF_FFFF};
        tbl[5]  = '{2'd2, 32'h8000_0001, 32'd0,          5'd6,  32'h8000_0001};
        tbl[6]  = '{2'd3, 32'h1234_5678, 32'd0,          5'd7,  32'h1234_5678};
        tbl[7]  = '{2'd2, 32'h8000_0000, 32'd31,         5'd8,  32'hFFFF_FFFF};
        tbl[8]  = '{2'd0, 32'h0000_0001, 32'd31,         5'd9,  32'h8000_0000};
        tbl[9]  = '{2'd3, 32'h0000_0001, 32'd1,          5'd10, 32'h8000_0000};
        tbl[10] = '{2'd0, 32'hDEAD_BEEF, 32'hFFFF_FFE0,  5'd31, 32'hDEAD_BEEF};

        for (int d = 0; d < NDUT; d++) begin
            valid_v[d] = 1'b0; mode_bus[d] = 2'd0; a_bus[d] = 64'd0;
            b_bus[d] = 64'd0; tag_bus[d] = 5'd0;
        end
        i_flush = 1'b0;
        i_ready = 1'b1;

        // Reset held two cycles with a valid op offered.
        i_reset = 1'b1;
        drive0(1'b1, 2'd0, 64'hFFFF_FFFF, 64'd1, 5'd31);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_valid", {63'd0, ov0}, 64'd0);
            chk("reset_data", get_data(0), 64'd0);
            chk("reset_tag", {59'd0, t0}, 64'd0);
        end
        i_reset = 1'b0;
        drive0(1'b0, 2'd0, 64'd0, 64'd0, 5'd0);
        @(negedge clk);
        chk("post_reset_valid", {63'd0, ov0}, 64'd0);
        chk("post_reset_ready", {63'd0, ordy0}, 64'd1);

        // Directed table: each op must surface exactly two cycles after accept.
        for (int i = 0; i < 11; i++) begin
            drive0(1'b1, tbl[i].mode, {32'd0, tbl[i].a}, {32'd0, tbl[i].b}, tbl[i].tag);
            @(negedge clk);
            drive0(1'b0, 2'd0, 64'd0, 64'd0, 5'd0);
            chk("tbl_early_valid", {63'd0, ov0}, 64'd0);
            @(negedge clk);
            chk("tbl_valid", {63'd0, ov0}, 64'd1);
            chk("tbl_data", get_data(0), {32'd0, tbl[i].exp});
            chk("tbl_tag", {59'd0, t0}, {59'd0, tbl[i].tag});
        end
        @(negedge clk);

        // Backpressure: tags 1..5 back-to-back, 3-cycle stall once tag 1 shows.
        rx_cnt = 0; next_tag = 1; stall_left = -1; prev_stall = 1'b0;
        prev_data = 32'd0; prev_tag = 5'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (stall_left < 0 && ov0 && t0 == 5'd1) stall_left = 3;
            rdy = !(stall_left > 0);
            i_ready = rdy;
            if (prev_stall) begin
                chk("bp_hold_valid", {63'd0, ov0}, 64'd1);
                chk("bp_hold_data", get_data(0), {32'd0, prev_data});
                chk("bp_hold_tag", {59'd0, t0}, {59'd0, prev_tag});
            end
            prev_data = d0; prev_tag = t0; prev_stall = !rdy;
            exp_rdy = rdy || !ov0;
            if (ov0 && rdy && rx_cnt < 8) begin
                rx_tag[rx_cnt] = t0; rx_data[rx_cnt] = d0; rx_cnt++;
            end
            if (next_tag <= 5) drive0(1'b1, 2'd0, 64'(next_tag), 64'd1, 5'(next_tag));
            else drive0(1'b0, 2'd0, 64'd0, 64'd0, 5'd0);
            #1;
            chk("bp_ready", {63'd0, ordy0}, {63'd0, exp_rdy});
            if (next_tag <= 5 && exp_rdy) next_tag++;
            if (stall_left > 0) stall_left--;
            @(negedge clk);
        end
        chk("bp_count", 64'(rx_cnt), 64'd5);
        for (int i = 0; i < 5 && i < rx_cnt; i++) begin
            chk("bp_order_tag", {59'd0, rx_tag[i]}, 64'(i + 1));
            chk("bp_order_data", {32'd0, rx_data[i]}, 64'((i + 1) * 2));
        end
        i_ready = 1'b1;

        // Flush: tags 7 and 8 in flight and never retired, killed by flush.
        i_ready = 1'b0;
        drive0(1'b1, 2'd1, 64'd7, 64'd0, 5'd7);
        @(negedge clk);
        chk("fl_empty0", {63'd0, ov0}, 64'd0);
        drive0(1'b1, 2'd1, 64'd8, 64'd0, 5'd8);
        @(negedge clk);
        i_flush = 1'b1;
        drive0(1'b1, 2'd1, 64'd9, 64'd0, 5'd9);
        @(negedge clk);
        chk("fl_killed", {63'd0, ov0}, 64'd0);
        // Second flush with o_ready high: the offered tag 9 must be dropped.
        i_ready = 1'b1;
        #1;
        chk("fl_ready_high", {63'd0, ordy0}, 64'd1);
        @(negedge clk);
        chk("fl_dropped", {63'd0, ov0}, 64'd0);
        i_flush = 1'b0;
        drive0(1'b1, 2'd0, 64'hA, 64'd1, 5'd10);
        @(negedge clk);
        drive0(1'b0, 2'd0, 64'd0, 64'd0, 5'd0);
        chk("fl_next_early", {63'd0, ov0}, 64'd0);
        @(negedge clk);
        chk("fl_next_valid", {63'd0, ov0}, 64'd1);
        chk("fl_next_tag", {59'd0, t0}, 64'd10);
        chk("fl_next_data", get_data(0), 64'h14);
        @(negedge clk);
        chk("fl_next_gone", {63'd0, ov0}, 64'd0);

        // Randomized traffic on all three instances against the reference model.
        for (int d = 0; d < NDUT; d++) begin
            head[d] = 0; cnt[d] = 0; advs[d] = 0;
        end
        for (int cyc = 0; cyc < 15000; cyc++) begin
            for (int d = 0; d < NDUT; d++) begin
                exp_v[d] = (cnt[d] > 0) && (advs[d] >= fifo[d][head[d]].due);
                chk("rnd_valid", {63'd0, get_valid(d)}, {63'd0, exp_v[d]});
                if (exp_v[d]) begin
                    chk("rnd_data", get_data(d), fifo[d][head[d]].data);
                    chk("rnd_tag", {59'd0, get_tag(d)}, {59'd0, fifo[d][head[d]].tag});
                end
            end
            i_ready = ($urandom_range(0, 9) < 8);
            i_flush = ($urandom_range(0, 99) == 0);
            for (int d = 0; d < NDUT; d++) begin
                valid_v[d]  = ($urandom_range(0, 9) < 9);
                mode_bus[d] = 2'($urandom_range(0, 3));
                a_bus[d]    = {$urandom, $urandom};
                b_bus[d]    = {$urandom, $urandom};
                tag_bus[d]  = 5'($urandom_range(0, 31));
            end
            #1;
            for (int d = 0; d < NDUT; d++) begin
                exp_rdy = !exp_v[d] || i_ready;
                chk("rnd_ready", {63'd0, get_ready(d)}, {63'd0, exp_rdy});
                if (i_flush) begin
                    cnt[d] = 0;
                end else begin
                    if (exp_v[d] && i_ready) begin
                        head[d] = (head[d] + 1) % 8;
                        cnt[d]--;
                    end
                    if (valid_v[d] && exp_rdy) begin
                        // Result shows once STAGES advancing edges have passed.
                        fifo[d][(head[d] + cnt[d]) % 8] = '{
                            ref_shift(a_bus[d], b_bus[d], mode_bus[d], W[d]),
                            tag_bus[d], advs[d] + STG[d]};
                        cnt[d]++;
                    end
                end
                if (exp_rdy) advs[d]++;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
